stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Control front end for the BCD stopwatch chain. Debounces the two DE10-Lite push
//  keys, runs an IDLE/RUN/STOP/LAP state machine, and produces the gated time-base
//  tick, the counter enable, the counter clear and the display-freeze (lap) signal
//  consumed by the cascaded BCD_counter stages and the SevenSeg display path.
// PARAMETERS
//  CLK_HZ        50_000_000  input clock frequency
//  TICK_HZ       1000        time-base tick rate; DIV = CLK_HZ/TICK_HZ, must be an integer >= 2
//  DEBOUNCE_CYC  1_000_000   consecutive clk cycles a key must disagree with the stable level (20 ms)
//  SYNC_STAGES   2           key synchronizer depth (>= 2)
// PORTS
//  clk          in   1  single clock (MAX10_CLK1_50 at top level)
//  clear_       in   1  asynchronous active-low reset
//  key_start_n  in   1  KEY[0], raw, active-low: start/stop
//  key_lap_n    in   1  KEY[1], raw, active-low: lap/resume, reset from STOP
//  tick         out  1  one-clk pulse every DIV clks while running
//  count_en     out  1  level: 1 in RUN or LAP
//  count_clr_   out  1  active-low counter clear: 0 while state == IDLE
//  lap_hold     out  1  1 in LAP: display path freezes the shown value
//  state        out  2  IDLE=0, RUN=1, STOP=2, LAP=3
// BEHAVIOUR
//  Reset (clear_=0, async): state=IDLE, tick=0, count_en=0, count_clr_=0, lap_hold=0,
//   synchronizers=1 (released), stable levels=1, debounce counters=0, phase=0.
//  Synchronizer: SYNC_STAGES flops per key; the raw pins never reach logic directly.
//  Debounce (per key): cnt clears whenever sync == stable; otherwise cnt increments.
//   When cnt == DEBOUNCE_CYC-1 and still disagreeing, stable <= sync and cnt <= 0.
//   Any pulse shorter than DEBOUNCE_CYC cycles is ignored.
//  Press event: registered one-clk pulse on a stable 1->0 transition. Releases produce
//   no event. Holding a key produces exactly one event.
//  Latency: pin low sampled at edge 1 -> press pulse high for the cycle after edge
//   SYNC_STAGES+DEBOUNCE_CYC+1 -> state updates on the following edge.
//  FSM transitions (start = start press, lap = lap press):
//   IDLE: start->RUN; lap ignored.     RUN: start->STOP; lap->LAP.
//   LAP:  start->STOP; lap->RUN.       STOP: start->RUN; lap->IDLE.
//   If start and lap press in the same cycle, start wins and lap is discarded.
//  Outputs are registered and decoded from state; they change on the same edge as state.
//  Phase counter ph (clog2(DIV) bits): increments in RUN/LAP, wraps at DIV-1 -> 0;
//   holds in STOP, so the sub-tick phase is preserved across pause/resume; forced to 0 in IDLE.
//  tick: registered 1 in the cycle after the edge where ph wraps. On IDLE->RUN the first
//   tick follows DIV running edges; thereafter period = DIV, duty 1 clk.
//   tick is never asserted in IDLE or STOP.
//  LAP keeps counting (count_en=1, tick continues); only lap_hold differs from RUN.
//  Reset mid-operation: immediate return to the reset values; a key held through
//   reset release is treated as released->pressed (one event after debounce).
// TESTING (CLK_HZ=100, TICK_HZ=10 -> DIV=10, DEBOUNCE_CYC=4, SYNC_STAGES=2)
//  1 Reset, start pressed 20 cycles -> state IDLE->RUN on edge 8 after the fall, count_clr_
//    1, count_en 1; the first tick occurs 10 cycles after RUN; later ticks have period 10.
//  2 In RUN, 3-cycle start glitch -> no event, state stays RUN, tick period unchanged.
//  3 RUN, start press 3 cycles after a tick -> STOP, no tick; resume -> first tick 7 running
//    cycles after re-entering RUN (phase preserved).
//  4 RUN: lap -> LAP, lap_hold=1, tick continues; lap -> RUN, lap_hold=0.
//  5 STOP: lap -> IDLE, count_clr_=0, ph=0; both keys fall in the same cycle while in RUN ->
//    STOP only.
//  6 Assert clear_ mid-LAP, asynchronous to clk -> all outputs reach reset values without
//    waiting for a clk edge; a key held through release -> one event.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front end: key synchronizers, debouncers, IDLE/RUN/STOP/LAP
// sequencer and the gated time-base tick for the cascaded BCD counter stages.
//
//   state | meaning
//   IDLE  | counters held clear, waiting for start
//   RUN   | counting, display live
//   STOP  | paused, counters and sub-tick phase held
//   LAP   | counting, display frozen
module stopwatch_ctrl #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int TICK_HZ      = 1000,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       clear_,
    input  logic       key_start_n,
    input  logic       key_lap_n,
    output logic       tick,
    output logic       count_en,
    output logic       count_clr_,
    output logic       lap_hold,
    output logic [1:0] state
);

    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int PH_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;
    localparam logic [1:0] S_LAP  = 2'd3;

    // index 0 = start key, index 1 = lap key
    logic [1:0]             key_raw;
    logic [SYNC_STAGES-1:0] sync_q   [2];
    logic [DB_W-1:0]        db_cnt   [2];
    logic [1:0]             stable_q;
    logic [1:0]             stable_d;
    logic [1:0]             press;

    assign key_raw = {key_lap_n, key_start_n};

    always_ff @(posedge clk or negedge clear_) begin
        if (!clear_) begin
            for (int k = 0; k < 2; k++) begin
                sync_q[k] <= '1;
                db_cnt[k] <= '0;
            end
            stable_q <= 2'b11;
            stable_d <= 2'b11;
            press    <= 2'b00;
        end else begin
            stable_d <= stable_q;
            press    <= stable_d & ~stable_q;
            for (int k = 0; k < 2; k++) begin
                sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], key_raw[k]};
                if (sync_q[k][SYNC_STAGES-1] == stable_q[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_LAST) begin
                    stable_q[k] <= sync_q[k][SYNC_STAGES-1];
                    db_cnt[k]   <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

    logic [1:0]      next_state;
    logic            running;
    logic            next_running;
    logic            ph_wrap;
    logic [PH_W-1:0] ph;

    // start has priority: a simultaneous lap press is simply dropped
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (press[0]) next_state = S_RUN;
            S_RUN: begin
                if (press[0])      next_state = S_STOP;
                else if (press[1]) next_state = S_LAP;
            end
            S_LAP: begin
                if (press[0])      next_state = S_STOP;
                else if (press[1]) next_state = S_RUN;
            end
            S_STOP: begin
                if (press[0])      next_state = S_RUN;
                else if (press[1]) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign running      = (state == S_RUN) || (state == S_LAP);
    assign next_running = (next_state == S_RUN) || (next_state == S_LAP);
    assign ph_wrap      = running && (ph == PH_LAST);

    always_ff @(posedge clk or negedge clear_) begin
        if (!clear_) begin
            state      <= S_IDLE;
            count_en   <= 1'b0;
            count_clr_ <= 1'b0;
            lap_hold   <= 1'b0;
            tick       <= 1'b0;
            ph         <= '0;
        end else begin
            state      <= next_state;
            count_en   <= next_running;
            count_clr_ <= (next_state != S_IDLE);
            lap_hold   <= (next_state == S_LAP);
            // a wrap on the edge that leaves RUN/LAP must not leak a tick into STOP
            tick       <= ph_wrap && next_running;
            if (next_state == S_IDLE) begin
                ph <= '0;
            end else if (running) begin
                ph <= ph_wrap ? '0 : ph + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=10, DEBOUNCE_CYC=4, SYNC_STAGES=2.
// All timing is expressed relative to R, the edge on which the first RUN is entered.
module tb_stopwatch_ctrl;

    logic       clk;
    logic       clear_;
    logic       key_start_n;
    logic       key_lap_n;
    logic       tick;
    logic       count_en;
    logic       count_clr_;
    logic       lap_hold;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_tick = -1;
    int prev_tick = -1;
    int tick_cnt  = 0;
    int c0, r, c1, base;

    stopwatch_ctrl #(
        .CLK_HZ(100), .TICK_HZ(10), .DEBOUNCE_CYC(4), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .clear_(clear_), .key_start_n(key_start_n), .key_lap_n(key_lap_n),
        .tick(tick), .count_en(count_en), .count_clr_(count_clr_),
        .lap_hold(lap_hold), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of rising edges so far; tick sampled 1 time unit after each edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (tick === 1'b1) begin
            prev_tick = last_tick;
            last_tick = cyc;
            tick_cnt  = tick_cnt + 1;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        clear_      = 1'b0;
        key_start_n = 1'b1;
        key_lap_n   = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_tick", tick, 0);
        chk("rst_count_en", count_en, 0);
        chk("rst_count_clr_", count_clr_, 0);
        chk("rst_lap_hold", lap_hold, 0);
        clear_ = 1'b1;
        repeat (2) @(negedge clk);

        // 1: start press, IDLE->RUN on edge 8, first tick 10 cycles later, then period 10
        c0 = cyc;
        r  = c0 + 8;
        base = tick_cnt;
        key_start_n = 1'b0;
        goto(c0 + 7);
        chk("t1_idle_before_edge8", state, 0);
        goto(r);
        chk("t1_run_state", state, 1);
        chk("t1_count_en", count_en, 1);
        chk("t1_count_clr_", count_clr_, 1);
        chk("t1_lap_hold", lap_hold, 0);
        goto(r + 12);
        key_start_n = 1'b1;
        chk("t1_first_tick", last_tick, r + 10);
        chk("t1_tick_count", tick_cnt - base, 1);
        goto(r + 30);
        chk("t1_tick_last", last_tick, r + 30);
        chk("t1_tick_prev", prev_tick, r + 20);
        chk("t1_tick_count3", tick_cnt - base, 3);
        chk("t1_release_no_event", state, 1);

        // 2: 3-cycle glitch on start is rejected
        goto(r + 31);
        key_start_n = 1'b0;
        goto(r + 34);
        key_start_n = 1'b1;

        // 3: stop 3 cycles after a tick, resume -> tick 7 running cycles later
        goto(r + 45);
        chk("t2_glitch_state", state, 1);
        chk("t2_glitch_tick", last_tick, r + 40);
        key_start_n = 1'b0;
        goto(r + 50);
        chk("t2_period_last", last_tick, r + 50);
        chk("t2_period_prev", prev_tick, r + 40);
        goto(r + 52);
        chk("t3_still_run", state, 1);
        goto(r + 53);
        chk("t3_stop_state", state, 2);
        chk("t3_stop_count_en", count_en, 0);
        chk("t3_stop_count_clr_", count_clr_, 1);
        goto(r + 60);
        key_start_n = 1'b1;
        goto(r + 75);
        chk("t3_stop_no_tick", last_tick, r + 50);
        chk("t3_stop_held", state, 2);
        key_start_n = 1'b0;
        goto(r + 82);
        key_start_n = 1'b1;
        chk("t3_stop_before_resume", state, 2);
        goto(r + 83);
        chk("t3_resume_state", state, 1);
        chk("t3_resume_count_en", count_en, 1);
        goto(r + 89);
        chk("t3_resume_no_early_tick", last_tick, r + 50);
        goto(r + 90);
        chk("t3_resume_tick_phase", last_tick, r + 90);

        // 4: lap enters LAP with ticks continuing, second lap returns to RUN
        goto(r + 92);
        key_lap_n = 1'b0;
        goto(r + 98);
        key_lap_n = 1'b1;
        goto(r + 100);
        chk("t4_lap_state", state, 3);
        chk("t4_lap_hold", lap_hold, 1);
        chk("t4_lap_count_en", count_en, 1);
        chk("t4_lap_tick_now", tick, 1);
        goto(r + 110);
        chk("t4_lap_tick_continues", last_tick, r + 110);
        goto(r + 111);
        key_lap_n = 1'b0;
        goto(r + 117);
        key_lap_n = 1'b1;
        goto(r + 119);
        chk("t4_back_run", state, 1);
        chk("t4_back_lap_hold", lap_hold, 0);
        goto(r + 120);
        chk("t4_back_tick", last_tick, r + 120);

        // 5: both keys together in RUN -> STOP only; then lap from STOP -> IDLE, ph cleared
        goto(r + 121);
        key_start_n = 1'b0;
        key_lap_n   = 1'b0;
        goto(r + 127);
        key_start_n = 1'b1;
        key_lap_n   = 1'b1;
        goto(r + 129);
        chk("t5_both_stop", state, 2);
        goto(r + 140);
        chk("t5_both_lap_discarded", state, 2);
        chk("t5_stop_no_tick", last_tick, r + 120);
        key_lap_n = 1'b0;
        goto(r + 146);
        key_lap_n = 1'b1;
        goto(r + 148);
        chk("t5_idle_state", state, 0);
        chk("t5_idle_count_clr_", count_clr_, 0);
        chk("t5_idle_count_en", count_en, 0);
        goto(r + 150);
        key_start_n = 1'b0;
        goto(r + 156);
        key_start_n = 1'b1;
        goto(r + 158);
        chk("t5_restart_run", state, 1);
        goto(r + 167);
        chk("t5_ph_cleared_no_early", last_tick, r + 120);
        goto(r + 168);
        chk("t5_ph_cleared_tick", last_tick, r + 168);

        // 6: asynchronous clear mid-LAP, start key held through release -> one event
        goto(r + 170);
        key_lap_n = 1'b0;
        goto(r + 176);
        key_lap_n = 1'b1;
        goto(r + 178);
        chk("t6_lap_state", state, 3);
        goto(r + 180);
        key_start_n = 1'b0;
        #2;
        clear_ = 1'b0;
        #1;
        chk("t6_async_state", state, 0);
        chk("t6_async_count_en", count_en, 0);
        chk("t6_async_count_clr_", count_clr_, 0);
        chk("t6_async_lap_hold", lap_hold, 0);
        chk("t6_async_tick", tick, 0);
        goto(r + 183);
        clear_ = 1'b1;
        c1 = cyc;
        goto(c1 + 7);
        chk("t6_held_idle", state, 0);
        goto(c1 + 8);
        chk("t6_held_event_run", state, 1);
        chk("t6_held_count_clr_", count_clr_, 1);
        goto(c1 + 30);
        chk("t6_held_single_event", state, 1);
        key_start_n = 1'b1;
        goto(c1 + 40);
        chk("t6_release_no_event", state, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
